// File: rtl/multicycle_alu_if.sv
// Handshake/data bundle for multicycle_alu.
//
// Handshake: the master raises start together with a, b and alucontrol; the
// op is taken on a rising edge where start=1 and ready=1, and the master may
// change a, b and alucontrol freely afterwards. start while ready=0 has no
// effect. done is a one-cycle pulse; result and Z/C/V/N are valid from that
// cycle and stay held until the next done. dbg_state mirrors the control FSM
// state (0=IDLE, 1=BUSY, 2=DONE).
interface multicycle_alu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alucontrol;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             Z;
  logic             C;
  logic             V;
  logic             N;
  logic [1:0]       dbg_state;

  modport master (
    output start, a, b, alucontrol,
    input  ready, busy, done, result, Z, C, V, N, dbg_state
  );

  modport slave (
    input  start, a, b, alucontrol,
    output ready, busy, done, result, Z, C, V, N, dbg_state
  );
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu: execute-stage ALU. Base ops finish in one clock; MUL/MULHU/
// DIVU/REMU iterate one bit per clock (WIDTH iterations) in a shared
// shift/add-subtract datapath. Result and flags are registered and held.
// Optional feature macro: MULTICYCLE_ALU_SIGNED_DIV_EN enables signed DIV (1100)
// and REM (1101) on top of the unsigned divider; without it those codes are
// treated as undefined (single-cycle, result 0).
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  multicycle_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLL   = 4'b0110;
  localparam logic [3:0] OP_LUI   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_REMU  = 4'b1011;
`ifdef MULTICYCLE_ALU_SIGNED_DIV_EN
  localparam logic [3:0] OP_DIV   = 4'b1100;
  localparam logic [3:0] OP_REM   = 4'b1101;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;   // divider vs multiplier mode for the iteration
  logic             r_want_hi;  // MULHU/REMU/REM return the upper register
  logic [WIDTH:0]   r_hi;       // product high half / partial remainder
  logic [WIDTH-1:0] r_lo;       // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] r_opnd;     // multiplicand / divisor
  logic [WIDTH-1:0] r_result;
  logic             r_z;
  logic             r_c;
  logic             r_v;
  logic             r_n;

  logic             w_accept;
  logic             w_is_iter;
  logic             w_last;
  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_sc_result;
  logic             w_sc_c;
  logic             w_sc_v;
  logic [WIDTH:0]   w_mul_hi;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic             w_q_bit;
  logic [WIDTH:0]   w_nxt_hi;
  logic [WIDTH-1:0] w_nxt_lo;
  logic [WIDTH-1:0] w_it_result;

`ifdef MULTICYCLE_ALU_SIGNED_DIV_EN
  logic             r_neg_q;
  logic             r_neg_r;
  logic             w_signed_op;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  assign w_signed_op = (bus.alucontrol == OP_DIV) || (bus.alucontrol == OP_REM);
  assign w_mag_a     = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign w_mag_b     = bus.b[WIDTH-1] ? -bus.b : bus.b;
`endif

  assign w_accept = bus.start && (r_state == S_IDLE);
  // The final iteration is the one that takes the counter from 1 to 0.
  assign w_last   = (r_cnt == CNT_ONE);

  assign bus.result    = r_result;
  assign bus.Z         = r_z;
  assign bus.C         = r_c;
  assign bus.V         = r_v;
  assign bus.N         = r_n;
  assign bus.dbg_state = r_state;

  // Classify the requested op: iterative ops go through BUSY.
  always_comb begin
    w_is_iter = 1'b0;
    case (bus.alucontrol)
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: w_is_iter = 1'b1;
`ifdef MULTICYCLE_ALU_SIGNED_DIV_EN
      OP_DIV, OP_REM:                     w_is_iter = 1'b1;
`endif
      default:                            w_is_iter = 1'b0;
    endcase
  end

  // Control FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Control FSM next state and status outputs.
  always_comb begin
    w_next_state = r_state;
    bus.ready    = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (w_accept) w_next_state = w_is_iter ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        bus.busy = 1'b1;
        if (w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        bus.done     = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Single-cycle ops, evaluated straight from the bus operands at acceptance.
  always_comb begin
    w_sub       = (bus.alucontrol == OP_SUB);
    w_b_eff     = w_sub ? ~bus.b : bus.b;
    w_sum       = {1'b0, bus.a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    w_sc_result = '0;
    w_sc_c      = 1'b0;
    w_sc_v      = 1'b0;
    case (bus.alucontrol)
      OP_ADD, OP_SUB: begin
        w_sc_result = w_sum[WIDTH-1:0];
        w_sc_c      = w_sum[WIDTH];
        w_sc_v      = (bus.a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: w_sc_result = bus.a & bus.b;
      OP_OR:  w_sc_result = bus.a | bus.b;
      OP_SLT: w_sc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLL: w_sc_result = bus.a << bus.b[SHW-1:0];
      OP_LUI: w_sc_result = bus.b;
      default: w_sc_result = '0;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide, plus the value
  // the op would return if this is the last iteration.
  always_comb begin
    w_mul_hi    = r_lo[0] ? (r_hi + {1'b0, r_opnd}) : r_hi;
    w_div_shift = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_opnd};
    w_q_bit     = ~w_div_diff[WIDTH];
    if (r_is_div) begin
      // A zero divisor always "fits", giving all-ones quotient, remainder=a.
      w_nxt_hi = w_q_bit ? w_div_diff : w_div_shift;
      w_nxt_lo = {r_lo[WIDTH-2:0], w_q_bit};
    end else begin
      w_nxt_hi = {1'b0, w_mul_hi[WIDTH:1]};
      w_nxt_lo = {w_mul_hi[0], r_lo[WIDTH-1:1]};
    end
    w_it_result = r_want_hi ? w_nxt_hi[WIDTH-1:0] : w_nxt_lo;
`ifdef MULTICYCLE_ALU_SIGNED_DIV_EN
    if (r_is_div) begin
      if (r_want_hi && r_neg_r)       w_it_result = -w_nxt_hi[WIDTH-1:0];
      else if (!r_want_hi && r_neg_q) w_it_result = -w_nxt_lo;
    end
`endif
  end

  // Operand capture, iteration registers, counter and held result/flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_want_hi <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opnd    <= '0;
      r_result  <= '0;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
      r_v       <= 1'b0;
      r_n       <= 1'b0;
`ifdef MULTICYCLE_ALU_SIGNED_DIV_EN
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_is_div  <= bus.alucontrol[2] | bus.alucontrol[1];
      r_want_hi <= bus.alucontrol[0];
      r_hi      <= '0;
      if (bus.alucontrol[2] | bus.alucontrol[1]) begin
        r_lo   <= bus.a;
        r_opnd <= bus.b;
      end else begin
        r_lo   <= bus.b;
        r_opnd <= bus.a;
      end
`ifdef MULTICYCLE_ALU_SIGNED_DIV_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      if (w_signed_op) begin
        r_lo    <= w_mag_a;
        r_opnd  <= w_mag_b;
        // x/0 keeps the raw all-ones quotient, so no sign fix-up then.
        r_neg_q <= (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) && (bus.b != '0);
        r_neg_r <= bus.a[WIDTH-1];
      end
`endif
      if (w_is_iter) begin
        r_cnt <= CNT_LOAD;
      end else begin
        r_result <= w_sc_result;
        r_z      <= (w_sc_result == '0);
        r_n      <= w_sc_result[WIDTH-1];
        r_c      <= w_sc_c;
        r_v      <= w_sc_v;
      end
    end else if (r_state == S_BUSY) begin
      r_hi  <= w_nxt_hi;
      r_lo  <= w_nxt_lo;
      r_cnt <= r_cnt - CNT_ONE;
      if (w_last) begin
        r_result <= w_it_result;
        r_z      <= (w_it_result == '0);
        r_n      <= w_it_result[WIDTH-1];
        r_c      <= 1'b0;
        r_v      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// Testbench for multicycle_alu (WIDTH=32): directed vector table, random ops
// against a behavioural model, and hand-written handshake/reset sequences.
module tb_multicycle_alu;
  localparam int W = 32;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flg;   // {Z, C, V, N}
    int           lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [W+3:0] exp_q[$];
  vec_t vecs[$];

  multicycle_alu_if #(.WIDTH(W)) bus();
  multicycle_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W+3:0] ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0]        r;
    logic                c;
    logic                v;
    logic [2*W-1:0]      p;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    r  = '0;
    c  = 1'b0;
    v  = 1'b0;
    p  = (2*W)'(a) * (2*W)'(b);
    case (op)
      4'h0: begin
        {c, r} = (W+1)'(a) + (W+1)'(b);
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'h1: begin
        r = a - b;
        c = (a >= b);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h5: r = (sa < sb) ? W'(1) : W'(0);
      4'h6: r = a << b[4:0];
      4'h7: r = b;
      4'h8: r = p[W-1:0];
      4'h9: r = p[2*W-1:W];
      4'hA: r = (b == '0) ? '1 : a / b;
      4'hB: r = (b == '0) ? a : a % b;
`ifdef MULTICYCLE_ALU_SIGNED_DIV_EN
      4'hC: begin
        if (b == '0)                   r = '1;
        else if (a == MINV && b == '1) r = a;
        else                           r = sa / sb;
      end
      4'hD: begin
        if (b == '0)                   r = a;
        else if (a == MINV && b == '1) r = '0;
        else                           r = sa % sb;
      end
`endif
      default: r = '0;
    endcase
    return {r, (r == '0), c, v, r[W-1]};
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    if (op >= 4'h8 && op <= 4'hB) return W + 1;
`ifdef MULTICYCLE_ALU_SIGNED_DIV_EN
    if (op == 4'hC || op == 4'hD) return W + 1;
`endif
    return 1;
  endfunction

  task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic [3:0] flg, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.flg = flg; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Issue one op, wait for done, check result/flags/latency/handshake.
  // With poke=1 an ADD start is pulsed during the 5th cycle after acceptance.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] e_res, input logic [3:0] e_flg, input int e_lat,
                       input bit poke, input string tag);
    int           lat;
    int           nbusy;
    int           guard;
    logic [W+3:0] exp;
    exp_q.push_back({e_res, e_flg});
    guard = 0;
    while (!bus.ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.ready) begin
      check({tag, " ready_timeout"}, 64'(bus.ready), 64'(1));
      exp = exp_q.pop_front();
      return;
    end
    bus.start      = 1'b1;
    bus.a          = a;
    bus.b          = b;
    bus.alucontrol = op;
    @(posedge clk);
    @(negedge clk);
    bus.start      = 1'b0;
    bus.a          = $urandom;
    bus.b          = $urandom;
    bus.alucontrol = 4'($urandom_range(0, 15));
    lat   = 1;
    nbusy = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) nbusy++;
      if (poke && lat == 5) begin
        bus.start      = 1'b1;
        bus.a          = 32'd1;
        bus.b          = 32'd1;
        bus.alucontrol = 4'h0;
      end
      @(negedge clk);
      if (poke && lat == 5) bus.start = 1'b0;
      lat++;
    end
    exp = exp_q.pop_front();
    check({tag, " latency"}, 64'(lat), 64'(e_lat));
    check({tag, " busy_cycles"}, 64'(nbusy), 64'((e_lat == 1) ? 0 : W));
    check({tag, " result"}, 64'(bus.result), 64'(exp[W+3:4]));
    check({tag, " flags"}, 64'({bus.Z, bus.C, bus.V, bus.N}), 64'(exp[3:0]));
    check({tag, " ready_in_done"}, 64'(bus.ready), 64'(0));
    @(negedge clk);
    check({tag, " ready_done_after"}, 64'({bus.ready, bus.done}), 64'(2'b10));
    check({tag, " result_held"}, 64'(bus.result), 64'(e_res));
  endtask

  initial begin
    int           guard;
    int           nbusy;
    int           ndone;
    logic [3:0]   op;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W+3:0] m;

    // Reset, with a start request that reset must override.
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.alucontrol = 4'h0;
    repeat (3) @(negedge clk);
    check("reset ready/busy/done", 64'({bus.ready, bus.busy, bus.done}), 64'(3'b100));
    check("reset result", 64'(bus.result), 64'(0));
    check("reset flags", 64'({bus.Z, bus.C, bus.V, bus.N}), 64'(0));
    check("reset state", 64'(bus.dbg_state), 64'(0));
    bus.start      = 1'b1;
    bus.a          = 32'd3;
    bus.b          = 32'd4;
    bus.alucontrol = 4'h0;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("reset_wins done", 64'(bus.done), 64'(0));
    check("reset_wins result", 64'(bus.result), 64'(0));

    // Directed vectors.
    add_vec(4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100, 1);
    add_vec(4'h1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0110, 1);
    add_vec(4'h5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1);
    add_vec(4'h1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b0001, 1);
    add_vec(4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0011, 1);
    add_vec(4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0001, 1);
    add_vec(4'h3, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000, 1);
    add_vec(4'h6, 32'h00000001, 32'h00000023, 32'h00000008, 4'b0000, 1);
    add_vec(4'h7, 32'hDEADBEEF, 32'h12345000, 32'h12345000, 4'b0000, 1);
    add_vec(4'h4, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1000, 1);
    add_vec(4'hF, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1000, 1);
    add_vec(4'h8, 32'h00010000, 32'h00010000, 32'h00000000, 4'b1000, 33);
    add_vec(4'h9, 32'h00010000, 32'h00010000, 32'h00000001, 4'b0000, 33);
    add_vec(4'hA, 32'd100,      32'd7,        32'h0000000E, 4'b0000, 33);
    add_vec(4'hB, 32'd100,      32'd7,        32'h00000002, 4'b0000, 33);
    add_vec(4'hA, 32'd5,        32'd0,        32'hFFFFFFFF, 4'b0001, 33);
    add_vec(4'hB, 32'd5,        32'd0,        32'h00000005, 4'b0000, 33);
`ifdef MULTICYCLE_ALU_SIGNED_DIV_EN
    add_vec(4'hC, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0001, 33);
    add_vec(4'hD, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 33);
    add_vec(4'hC, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 4'b0001, 33);
    add_vec(4'hD, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 4'b0001, 33);
`else
    add_vec(4'hC, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 1);
    add_vec(4'hD, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 1);
    add_vec(4'hC, 32'hFFFFFFF9, 32'h00000002, 32'h00000000, 4'b1000, 1);
    add_vec(4'hD, 32'hFFFFFFF9, 32'h00000002, 32'h00000000, 4'b1000, 1);
`endif
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg, vecs[i].lat, 1'b0,
            $sformatf("vec%0d", i));
    end

    // Start pulsed while a DIVU is iterating must be ignored.
    do_op(4'hA, 32'd100, 32'd7, 32'h0000000E, 4'b0000, 33, 1'b1, "ignored_start");

    // Reset in the 10th BUSY cycle aborts the op.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.a          = 32'd1000;
    bus.b          = 32'd3;
    bus.alucontrol = 4'hA;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    nbusy     = 0;
    guard     = 0;
    while (guard < 50) begin
      if (bus.busy) nbusy++;
      if (nbusy == 10) break;
      @(negedge clk);
      guard++;
    end
    check("abort reached_busy10", 64'(nbusy), 64'(10));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort ready/busy", 64'({bus.ready, bus.busy}), 64'(2'b10));
    check("abort result", 64'(bus.result), 64'(0));
    ndone = 0;
    repeat (40) begin
      if (bus.done) ndone++;
      @(negedge clk);
    end
    check("abort no_done", 64'(ndone), 64'(0));

    // Random ops against the behavioural model.
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       begin ra = MINV; rb = '1; end
        default: rb = $urandom;
      endcase
      m = ref_model(op, ra, rb);
      do_op(op, ra, rb, m[W+3:4], m[3:0], ref_lat(op), 1'b0, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
